// File: rtl/naive_bus_pkg.sv
// Shared definitions for the naive_bus arbiter: owner encoding, bus widths
// and the conflict counter width.
package naive_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Width and saturation value of the conflict counter
  localparam int                CNT_W   = 16;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  // Read-data owner encoding, as seen on o_rd_owner
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  // Requester index carried by the select logic
  typedef enum logic {
    SEL_M0 = 1'b0,
    SEL_M1 = 1'b1
  } sel_e;

endpackage

// File: rtl/naive_bus.sv
// naive_bus interface: independent read and write request/grant channels.
// Read data returns one cycle after the read grant.
interface naive_bus;
  import naive_bus_pkg::*;

  logic              rd_req;
  logic              rd_gnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic              wr_gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  // The side that issues requests
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  // The side that grants requests and returns read data
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/naive_bus_arb_sel.sv
// Pure combinational requester selection. When both requesters want the bus
// the one not named by last_q wins; a single requester always wins at once.
// Feeding last_q with a constant 0 turns this into fixed priority for m1.
module naive_bus_arb_sel
  import naive_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_q,
  output sel_e sel,
  output logic valid
);

  // Pick at most one requester from the request lines and the last winner
  always_comb begin
    valid = req0 | req1;
    sel   = SEL_M0;
    if (req0 && req1) begin
      sel = last_q ? SEL_M0 : SEL_M1;
    end else if (req1) begin
      sel = SEL_M1;
    end
  end

endmodule

// File: rtl/naive_bus_arbiter2.sv
// Two-requester naive_bus arbiter. m0 is the instruction side, m1 the data
// side; both share one downstream port s.
// Build option NAIVE_BUS_ARB_RR_EN: defined -> round-robin between m0 and m1
// using last_q; undefined -> fixed priority with m1 always winning.
// Selection never looks at the slave grants, so request->grant is loop free.
module naive_bus_arbiter2
  import naive_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  naive_bus.slave          m0,
  naive_bus.slave          m1,
  naive_bus.master         s,
  output logic [CNT_W-1:0] o_conflict_cnt,
  output logic [1:0]       o_rd_owner
);

  logic             req0;
  logic             req1;
  logic             last_sel;
  sel_e             sel;
  logic             sel_valid;
  logic             fwd_rd_gnt;
  logic             fwd_wr_gnt;

  owner_e           rd_owner_reg;
  owner_e           rd_owner_next;
  logic [CNT_W-1:0] conflict_cnt_reg;
  logic [CNT_W-1:0] conflict_cnt_next;

  assign req0 = m0.rd_req | m0.wr_req;
  assign req1 = m1.rd_req | m1.wr_req;

`ifdef NAIVE_BUS_ARB_RR_EN
  logic last_q;

  // Remember the last granted requester; only a real grant moves it, so the
  // choice stays put while the slave stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (fwd_rd_gnt || fwd_wr_gnt) begin
      last_q <= sel;
    end
  end

  assign last_sel = last_q;
`else
  // Pretend m0 always won last time: with both requesting m1 is chosen
  assign last_sel = 1'b0;
`endif

  naive_bus_arb_sel u_sel (
    .req0   (req0),
    .req1   (req1),
    .last_q (last_sel),
    .sel    (sel),
    .valid  (sel_valid)
  );

  // Forward the selected requester's command and payload downstream
  always_comb begin
    s.rd_req  = 1'b0;
    s.rd_addr = '0;
    s.wr_req  = 1'b0;
    s.wr_addr = '0;
    s.wr_data = '0;
    s.wr_be   = '0;
    if (sel_valid) begin
      if (sel == SEL_M1) begin
        s.rd_req  = m1.rd_req;
        s.rd_addr = m1.rd_addr;
        s.wr_req  = m1.wr_req;
        s.wr_addr = m1.wr_addr;
        s.wr_data = m1.wr_data;
        s.wr_be   = m1.wr_be;
      end else begin
        s.rd_req  = m0.rd_req;
        s.rd_addr = m0.rd_addr;
        s.wr_req  = m0.wr_req;
        s.wr_addr = m0.wr_addr;
        s.wr_data = m0.wr_data;
        s.wr_be   = m0.wr_be;
      end
    end
  end

  // Route slave grants to the selected requester only
  always_comb begin
    fwd_rd_gnt = sel_valid & s.rd_gnt;
    fwd_wr_gnt = sel_valid & s.wr_gnt;
    m0.rd_gnt  = 1'b0;
    m0.wr_gnt  = 1'b0;
    m1.rd_gnt  = 1'b0;
    m1.wr_gnt  = 1'b0;
    if (sel == SEL_M1) begin
      m1.rd_gnt = fwd_rd_gnt;
      m1.wr_gnt = fwd_wr_gnt;
    end else begin
      m0.rd_gnt = fwd_rd_gnt;
      m0.wr_gnt = fwd_wr_gnt;
    end
  end

  // Return read data to whoever owned last cycle's read grant
  always_comb begin
    m0.rd_data = '0;
    m1.rd_data = '0;
    if (rd_owner_reg == OWN_M0) begin
      m0.rd_data = s.rd_data;
    end else if (rd_owner_reg == OWN_M1) begin
      m1.rd_data = s.rd_data;
    end
  end

  // Next read owner and saturating conflict count
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (fwd_rd_gnt) begin
      rd_owner_next = (sel == SEL_M1) ? OWN_M1 : OWN_M0;
    end
    conflict_cnt_next = conflict_cnt_reg;
    if (req0 && req1 && (conflict_cnt_reg != CNT_MAX)) begin
      conflict_cnt_next = conflict_cnt_reg + 1'b1;
    end
  end

  // Register read owner and conflict count; reset drops any pending read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner_reg     <= OWN_NONE;
      conflict_cnt_reg <= '0;
    end else begin
      rd_owner_reg     <= rd_owner_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  assign o_rd_owner     = rd_owner_reg;
  assign o_conflict_cnt = conflict_cnt_reg;

endmodule
